// File: rtl/packet_builder_pkg.sv
// Shared flit layout for the packet builder: field positions and widths,
// the packed flit struct and a small sizing helper.
package packet_builder_pkg;

  localparam int COORD_W     = 3;
  localparam int ADDR_W      = 3 * COORD_W;

  localparam int PAYLOAD_POS = 0;
  localparam int PAYLOAD_W   = 32;
  localparam int OP_POS      = 32;
  localparam int OP_W        = 4;
  localparam int ALG_POS     = 36;
  localparam int ALG_W       = 2;
  localparam int TAG_POS     = 38;
  localparam int TAG_W       = 8;
  localparam int CTX_POS     = 46;
  localparam int CTX_W       = 8;
  localparam int SRC_POS     = 54;
  localparam int DST_POS     = 63;
  localparam int VALID_POS   = 72;
  localparam int FLIT_WIDTH  = 73;

  // Field order matches the wire layout, MSB first.
  typedef struct packed {
    logic                 valid;
    logic [ADDR_W-1:0]    dst;
    logic [ADDR_W-1:0]    src;
    logic [CTX_W-1:0]     ctx;
    logic [TAG_W-1:0]     tag;
    logic [ALG_W-1:0]     alg;
    logic [OP_W-1:0]      op;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/packet_builder_if.sv
// Local-source request bus plus router-injection output of the packet builder.
// The builder uses the slave modport; the sources/sink side uses master.
interface packet_builder_if #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
);
  import packet_builder_pkg::*;

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic [NUM_CH-1:0]           in_valid;
  logic [NUM_CH-1:0]           in_ready;
  logic [NUM_CH*PAYLOAD_W-1:0] in_payload;
  logic [NUM_CH*OP_W-1:0]      in_op;
  logic [NUM_CH*ALG_W-1:0]     in_algtype;
  logic [NUM_CH*TAG_W-1:0]     in_tag;
  logic [NUM_CH*CTX_W-1:0]     in_context_id;
  logic [NUM_CH*ADDR_W-1:0]    in_dst;

  logic [FLIT_WIDTH-1:0]       out_flit;
  logic                        out_valid;
  logic                        out_ready;
  logic [CNT_W-1:0]            fifo_count;

  modport master (
    output in_valid, in_payload, in_op, in_algtype, in_tag, in_context_id, in_dst,
    output out_ready,
    input  in_ready, out_flit, out_valid, fifo_count
  );

  modport slave (
    input  in_valid, in_payload, in_op, in_algtype, in_tag, in_context_id, in_dst,
    input  out_ready,
    output in_ready, out_flit, out_valid, fifo_count
  );

endinterface

// File: rtl/packet_builder_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching upward from
// the channel after the last one granted. The pointer moves only on advance,
// so an un-accepted grant keeps its priority.
module packet_builder_rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]  last_q, last_d;
  logic [NUM_CH-1:0] hi_mask;
  logic [NUM_CH-1:0] req_hi;

  // Channels strictly above the last grant get first pick this round.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign hi_mask[gi] = (PTR_W'(gi) > last_q);
  end

  assign req_hi = req & hi_mask;

  // Lowest set bit of the upper half, else wrap around to the lowest overall.
  always_comb begin
    grant = '0;
    if (|req_hi) begin
      grant = req_hi & (~req_hi + NUM_CH'(1));
    end else begin
      grant = req & (~req + NUM_CH'(1));
    end
  end

  // Remember the channel just served so it drops to lowest priority.
  always_comb begin
    last_d = last_q;
    if (advance) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant[i]) last_d = PTR_W'(i);
      end
    end
  end

  // Reset to the top channel so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= PTR_W'(NUM_CH - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/packet_builder.sv
// Multi-channel packet builder: round-robin over local sources, stamps this
// node's coordinates, packs a 73-bit flit and queues it in a small FIFO
// toward the router injection port.
// Build option: PACKET_BUILDER_AUTO_TAG_EN replaces in_tag with a per-channel
// 8-bit counter that advances on every accept of that channel.
module packet_builder
  import packet_builder_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int RANK_X     = 0,
  parameter int RANK_Y     = 0,
  parameter int RANK_Z     = 0
) (
  input  logic             clk,
  input  logic             rst,
  packet_builder_if.slave  bus
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  localparam logic [COORD_W-1:0] SRC_X = COORD_W'(RANK_X);
  localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(RANK_Y);
  localparam logic [COORD_W-1:0] SRC_Z = COORD_W'(RANK_Z);

  logic [NUM_CH-1:0]       grant;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH-1:0]       accept;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [NUM_CH*TAG_W-1:0] tag_vec;

  logic [PAYLOAD_W-1:0]    sel_payload;
  logic [OP_W-1:0]         sel_op;
  logic [ALG_W-1:0]        sel_alg;
  logic [TAG_W-1:0]        sel_tag;
  logic [CTX_W-1:0]        sel_ctx;
  logic [ADDR_W-1:0]       sel_dst;
  flit_t                   flit_d;

  logic [FLIT_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  packet_builder_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.in_valid),
    .advance (push),
    .grant   (grant)
  );

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO blocks every source even if the head leaves this cycle, which
  // keeps in_ready free of any dependence on out_ready.
  assign in_ready     = grant & {NUM_CH{~full & ~rst}};
  assign accept       = bus.in_valid & in_ready;
  assign push         = |accept;
  assign pop          = ~empty & bus.out_ready & ~rst;
  assign bus.in_ready = in_ready;

`ifdef PACKET_BUILDER_AUTO_TAG_EN
  // Per-channel sequence counters; in_tag is not used in this build.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_tag
    logic [TAG_W-1:0] cnt_q, cnt_d;

    // Bump on each accept of this channel, wrapping naturally at 255.
    always_comb begin
      cnt_d = cnt_q;
      if (accept[gi]) cnt_d = cnt_q + TAG_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign tag_vec[TAG_W*gi +: TAG_W] = cnt_q;
  end
`else
  assign tag_vec = bus.in_tag;
`endif

  // Select the granted channel's fields (grant is one-hot or zero).
  always_comb begin
    sel_payload = '0;
    sel_op      = '0;
    sel_alg     = '0;
    sel_tag     = '0;
    sel_ctx     = '0;
    sel_dst     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_payload = bus.in_payload[PAYLOAD_W*i +: PAYLOAD_W];
        sel_op      = bus.in_op[OP_W*i +: OP_W];
        sel_alg     = bus.in_algtype[ALG_W*i +: ALG_W];
        sel_tag     = tag_vec[TAG_W*i +: TAG_W];
        sel_ctx     = bus.in_context_id[CTX_W*i +: CTX_W];
        sel_dst     = bus.in_dst[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Pack the flit; source is always this node, valid bit always set.
  always_comb begin
    flit_d         = '0;
    flit_d.valid   = 1'b1;
    flit_d.dst     = sel_dst;
    flit_d.src     = {SRC_Z, SRC_Y, SRC_X};
    flit_d.ctx     = sel_ctx;
    flit_d.tag     = sel_tag;
    flit_d.alg     = sel_alg;
    flit_d.op      = sel_op;
    flit_d.payload = sel_payload;
  end

  // FIFO storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= flit_d;
  end

  // Pointer and occupancy update; pointers wrap as the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head flit is presented straight from storage; zero whenever not valid.
  assign bus.out_valid  = ~empty & ~rst;
  assign bus.out_flit   = (empty || rst) ? '0 : mem[rd_ptr_q];
  assign bus.fifo_count = rst ? '0 : count_q;

endmodule

// File: tb/tb_packet_builder.sv
// Directed bench for packet_builder (2 channels, depth 4, rank x=4 y=5 z=6).
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_packet_builder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  packet_builder_if #(.NUM_CH(2), .FIFO_DEPTH(4)) bus ();

  packet_builder #(
    .NUM_CH     (2),
    .FIFO_DEPTH (4),
    .RANK_X     (4),
    .RANK_Y     (5),
    .RANK_Z     (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid      = '0;
    bus.in_payload    = '0;
    bus.in_op         = '0;
    bus.in_algtype    = '0;
    bus.in_tag        = '0;
    bus.in_context_id = '0;
    bus.in_dst        = '0;
    bus.out_ready     = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] pl, input logic [3:0] op,
                        input logic [1:0] alg, input logic [7:0] tag,
                        input logic [7:0] ctx, input logic [8:0] dst);
    bus.in_valid[ch]              = 1'b1;
    bus.in_payload[32*ch +: 32]   = pl;
    bus.in_op[4*ch +: 4]          = op;
    bus.in_algtype[2*ch +: 2]     = alg;
    bus.in_tag[8*ch +: 8]         = tag;
    bus.in_context_id[8*ch +: 8]  = ctx;
    bus.in_dst[9*ch +: 9]         = dst;
  endtask

  task automatic do_reset();
    to_pos();
    rst = 1'b1;
    clear_inputs();
    to_pos();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.in_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 00", bus.in_ready);
    end
    to_pos();
    rst = 1'b0;
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    checks++;
    if (bus.out_flit !== 73'd0) begin
      failures++;
      $display("FAIL reset_out_flit: got %h, required 0", bus.out_flit);
    end
    checks++;
    if (bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d, required 0", bus.fifo_count);
    end
    // Both request; channel 0 must win first. Withdraw before the edge.
    bus.in_valid = 2'b11;
    #1;
    checks++;
    if (bus.in_ready !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_grant: got %b, required 01", bus.in_ready);
    end
    bus.in_valid = '0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [72:0] exp_flit;
    logic [7:0]  exp_tag;
`ifdef PACKET_BUILDER_AUTO_TAG_EN
    exp_tag = 8'h00;
`else
    exp_tag = 8'h5A;
`endif
    exp_flit = {1'b1, 9'b001_010_011, 9'b110_101_100, 8'h3C, exp_tag, 2'b10, 4'hA, 32'hDEADBEEF};
    to_pos();
    set_ch(0, 32'hDEADBEEF, 4'hA, 2'b10, 8'h5A, 8'h3C, {3'd1, 3'd2, 3'd3});
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready: got %b, required 01", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_no_comb_path: got out_valid %b, required 0", bus.out_valid);
    end
    to_pos();
    bus.in_valid = '0;
    @(negedge clk);
    $display("accept ch0 flit %h", bus.out_flit);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_out_valid: got %b, required 1", bus.out_valid);
    end
    checks++;
    if (bus.out_flit !== exp_flit) begin
      failures++;
      $display("FAIL single_flit: got %h, required %h", bus.out_flit, exp_flit);
    end
    checks++;
    if (bus.out_flit[71:54] !== {9'b001_010_011, 9'b110_101_100}) begin
      failures++;
      $display("FAIL single_dst_src: got %b, required 001010011110101100", bus.out_flit[71:54]);
    end
    checks++;
    if (bus.fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL single_count: got %0d, required 1", bus.fifo_count);
    end
    bus.out_ready = 1'b1;
    to_pos();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_flit !== 73'd0 || bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL single_pop: got valid %b flit %h count %0d, required 0 0 0",
               bus.out_valid, bus.out_flit, bus.fifo_count);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] prev_pl;
    logic [7:0]  prev_tag;
    logic [1:0]  exp_g;
    do_reset();
    bus.out_ready = 1'b1;
    set_ch(0, 32'hA0A0_0000, 4'h1, 2'b01, 8'h11, 8'h01, 9'd5);
    set_ch(1, 32'hB1B1_0000, 4'h2, 2'b11, 8'h22, 8'h02, 9'd6);
    prev_pl  = '0;
    prev_tag = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if (bus.in_ready !== exp_g) begin
        failures++;
        $display("FAIL rr_grant_%0d: got %b, required %b", k, bus.in_ready, exp_g);
      end
      if (k > 0) begin
        $display("rr cycle %0d head payload %h", k, bus.out_flit[31:0]);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_flit[31:0] !== prev_pl || bus.fifo_count !== 3'd1) begin
          failures++;
          $display("FAIL rr_head_%0d: got valid %b payload %h count %0d, required 1 %h 1",
                   k, bus.out_valid, bus.out_flit[31:0], bus.fifo_count, prev_pl);
        end
`ifndef PACKET_BUILDER_AUTO_TAG_EN
        checks++;
        if (bus.out_flit[45:38] !== prev_tag) begin
          failures++;
          $display("FAIL rr_tag_%0d: got %h, required %h", k, bus.out_flit[45:38], prev_tag);
        end
`endif
      end
      prev_pl  = (k % 2 == 1) ? 32'hB1B1_0000 : 32'hA0A0_0000;
      prev_tag = (k % 2 == 1) ? 8'h22 : 8'h11;
      to_pos();
    end
    bus.in_valid = '0;
    to_pos();
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL rr_drain: got count %0d, required 0", bus.fifo_count);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 32'h100 + i, 4'h3, 2'b00, 8'h40, 8'h04, 9'd7);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 2'b01) begin
        failures++;
        $display("FAIL full_fill_%0d: got ready %b, required 01", i, bus.in_ready);
      end
      to_pos();
    end
    set_ch(0, 32'h104, 4'h3, 2'b00, 8'h40, 8'h04, 9'd7);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 2'b00 || bus.fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL full_block: got ready %b count %0d, required 00 4", bus.in_ready, bus.fifo_count);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 2'b00) begin
      failures++;
      $display("FAIL full_no_passthrough: got ready %b, required 00", bus.in_ready);
    end
    to_pos();
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 3'd3 || bus.in_ready !== 2'b01 || bus.out_flit[31:0] !== 32'h101) begin
      failures++;
      $display("FAIL full_after_pop: got count %0d ready %b head %h, required 3 01 00000101",
               bus.fifo_count, bus.in_ready, bus.out_flit[31:0]);
    end
    to_pos();
    bus.in_valid = '0;
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_flit[31:0] !== 32'h100 + i) begin
        failures++;
        $display("FAIL full_drain_%0d: got %h, required %h", i, bus.out_flit[31:0], 32'h100 + i);
      end
      to_pos();
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL full_empty: got valid %b count %0d, required 0 0", bus.out_valid, bus.fifo_count);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_push_pop_wrap();
    do_reset();
    bus.out_ready = 1'b0;
    set_ch(1, 32'hC0, 4'h5, 2'b01, 8'h77, 8'h07, 9'd9);
    to_pos();
    set_ch(1, 32'hC1, 4'h5, 2'b01, 8'h77, 8'h07, 9'd9);
    to_pos();
    set_ch(1, 32'hC2, 4'h5, 2'b01, 8'h77, 8'h07, 9'd9);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      $display("push/pop cycle %0d head %h count %0d", j, bus.out_flit[31:0], bus.fifo_count);
      checks++;
      if (bus.fifo_count !== 3'd2 || bus.in_ready !== 2'b10 || bus.out_flit[31:0] !== 32'hC0 + j) begin
        failures++;
        $display("FAIL wrap_%0d: got count %0d ready %b head %h, required 2 10 %h",
                 j, bus.fifo_count, bus.in_ready, bus.out_flit[31:0], 32'hC0 + j);
      end
      to_pos();
      set_ch(1, 32'hC3 + j, 4'h5, 2'b01, 8'h77, 8'h07, 9'd9);
    end
    bus.in_valid = '0;
    for (int j = 6; j < 8; j++) begin
      @(negedge clk);
      checks++;
      if (bus.out_flit[31:0] !== 32'hC0 + j) begin
        failures++;
        $display("FAIL wrap_drain_%0d: got %h, required %h", j, bus.out_flit[31:0], 32'hC0 + j);
      end
      to_pos();
    end
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_empty: got count %0d valid %b, required 0 0", bus.fifo_count, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 32'hD0 + i, 4'h6, 2'b10, 8'h12, 8'h08, 9'd1);
      to_pos();
    end
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL midrst_prefill: got count %0d, required 3", bus.fifo_count);
    end
    rst = 1'b1;
    set_ch(0, 32'hE0, 4'h6, 2'b10, 8'h12, 8'h08, 9'd1);
    set_ch(1, 32'hE1, 4'h6, 2'b10, 8'h13, 8'h08, 9'd1);
    #1;
    checks++;
    if (bus.in_ready !== 2'b00) begin
      failures++;
      $display("FAIL midrst_ready: got %b, required 00", bus.in_ready);
    end
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_flit !== 73'd0 || bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL midrst_cleared: got valid %b flit %h count %0d, required 0 0 0",
               bus.out_valid, bus.out_flit, bus.fifo_count);
    end
    checks++;
    if (bus.in_ready !== 2'b01) begin
      failures++;
      $display("FAIL midrst_ch0_first: got %b, required 01", bus.in_ready);
    end
    to_pos();
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_flit[31:0] !== 32'hE0) begin
      failures++;
      $display("FAIL midrst_after: got valid %b head %h, required 1 000000e0", bus.out_valid, bus.out_flit[31:0]);
    end
    bus.out_ready = 1'b1;
    to_pos();
    bus.out_ready = 1'b0;
  endtask

`ifdef PACKET_BUILDER_AUTO_TAG_EN
  task automatic test_auto_tag();
    do_reset();
    bus.out_ready = 1'b1;
    set_ch(0, 32'hF0, 4'h1, 2'b00, 8'h55, 8'h00, 9'd2);
    to_pos();
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_flit[45:38] !== 8'h00) begin
      failures++;
      $display("FAIL tag_ch0_first: got %h, required 00", bus.out_flit[45:38]);
    end
    set_ch(1, 32'hF1, 4'h1, 2'b00, 8'hEE, 8'h00, 9'd2);
    for (int n = 0; n < 257; n++) begin
      to_pos();
      if (n == 256) bus.in_valid = '0;
      @(negedge clk);
      checks++;
      if (bus.out_flit[45:38] !== 8'(n)) begin
        failures++;
        $display("FAIL tag_ch1_%0d: got %h, required %h", n, bus.out_flit[45:38], 8'(n));
      end
    end
    $display("ch1 sent 257 flits, last tag %h", bus.out_flit[45:38]);
    set_ch(0, 32'hF2, 4'h1, 2'b00, 8'h55, 8'h00, 9'd2);
    to_pos();
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_flit[45:38] !== 8'h01) begin
      failures++;
      $display("FAIL tag_ch0_second: got %h, required 01", bus.out_flit[45:38]);
    end
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_push_pop_wrap();
    test_reset_mid();
`ifdef PACKET_BUILDER_AUTO_TAG_EN
    test_auto_tag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
